// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between gate_truth_checker and the bench or
// the gate under test; the checker owns the slave side.
interface gate_truth_checker_if;
   logic       start;
   logic       z;
   logic       x;
   logic       y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;

   modport master (
      output start, z,
      input  x, y, busy, done, pass, err_count, fail_vec
   );

   modport slave (
      input  start, z,
      output x, y, busy, done, pass, err_count, fail_vec
   );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through all four input vectors, samples z after a
// programmable settle time and reports a mismatch map, count and pass flag.
module gate_truth_checker #(
   parameter logic [3:0] EXPECTED = 4'b1000,
   parameter int         SETTLE   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   gate_truth_checker_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

   state_t     state, state_nxt;
   logic [1:0] idx;
   logic [1:0] idx_inc;
   logic [3:0] cnt;
   logic       accept;
   logic       expire;
   logic       last;
   logic       mis;
   logic [2:0] err_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FIN accepts start just like IDLE so back-to-back runs lose no cycle.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      expire    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == 4'd1) begin
               expire = 1'b1;
               if (idx == 2'd3) begin
                  last      = 1'b1;
                  state_nxt = FIN;
               end
            end
         end
         FIN: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign idx_inc = idx + 2'd1;
   assign mis     = expire & (bus.z != EXPECTED[idx]);
   assign err_nxt = bus.err_count + {2'b00, mis};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx           <= 2'd0;
         cnt           <= 4'd0;
         bus.x         <= 1'b0;
         bus.y         <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.pass      <= 1'b0;
         bus.err_count <= 3'd0;
         bus.fail_vec  <= 4'd0;
      end else begin
         bus.done <= last;
         if (accept) begin
            idx           <= 2'd0;
            cnt           <= SETTLE_LD;
            bus.x         <= 1'b0;
            bus.y         <= 1'b0;
            bus.busy      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_vec  <= 4'd0;
         end else if (expire) begin
            if (mis) bus.fail_vec[idx] <= 1'b1;
            bus.err_count <= err_nxt;
            if (last) begin
               // pass is judged on the count including this final sample
               bus.busy <= 1'b0;
               bus.x    <= 1'b0;
               bus.y    <= 1'b0;
               bus.pass <= (err_nxt == 3'd0);
            end else begin
               idx   <= idx_inc;
               cnt   <= SETTLE_LD;
               bus.x <= idx_inc[1];
               bus.y <= idx_inc[0];
            end
         end else if (state == RUN) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboarded bench: two checkers (SETTLE 2 and 1) driving modelled gates.
module tb_gate_truth_checker;

   localparam logic [3:0] EXP = 4'b1000;

   typedef struct {
      int         dcyc;
      logic [3:0] fv;
      logic [2:0] ec;
      logic       ps;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   mode;
   int   n_tests;
   int   n_fail;
   exp_t q2[$];
   exp_t q1[$];
   exp_t e2;
   exp_t e1;

   gate_truth_checker_if bus2();
   gate_truth_checker_if bus1();

   gate_truth_checker #(.EXPECTED(4'b1000), .SETTLE(2)) u2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   gate_truth_checker #(.EXPECTED(4'b1000), .SETTLE(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // mode 0: AND gate, 1: OR gate, 2: stuck-at-0
   assign bus2.z = (mode == 0) ? (bus2.x & bus2.y) :
                   (mode == 1) ? (bus2.x | bus2.y) : 1'b0;
   assign bus1.z = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input int m, input int settle, input int e0);
      exp_t r;
      logic g;
      logic [1:0] v;
      r.dcyc = e0 + 4 * settle;
      r.fv   = 4'd0;
      r.ec   = 3'd0;
      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         g = (m == 0) ? (v[1] & v[0]) : (m == 1) ? (v[1] | v[0]) : 1'b0;
         if (g != EXP[i]) begin
            r.fv[i] = 1'b1;
            r.ec    = r.ec + 3'd1;
         end
      end
      r.ps = (r.ec == 3'd0);
      return r;
   endfunction

   always @(negedge clk) begin
      if (bus2.done) begin
         if (q2.size() == 0) chk("u2_unexpected_done", 1, 0);
         else begin
            e2 = q2.pop_front();
            chk("u2_done_cyc", cyc, e2.dcyc);
            chk("u2_fail_vec", bus2.fail_vec, e2.fv);
            chk("u2_err_count", bus2.err_count, e2.ec);
            chk("u2_pass", bus2.pass, e2.ps);
            chk("u2_busy_at_done", bus2.busy, 0);
         end
      end
      if (bus1.done) begin
         if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("u1_done_cyc", cyc, e1.dcyc);
            chk("u1_fail_vec", bus1.fail_vec, e1.fv);
            chk("u1_err_count", bus1.err_count, e1.ec);
            chk("u1_pass", bus1.pass, e1.ps);
         end
      end
   end

   task automatic start2(input int m);
      @(negedge clk);
      mode = m;
      bus2.start = 1'b1;
      q2.push_back(model(m, 2, cyc + 1));
      @(negedge clk);
      bus2.start = 1'b0;
   endtask

   task automatic wait_done2();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus2.done) return;
      end
      chk("u2_done_timeout", 0, 1);
   endtask

   task automatic wait_done1();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus1.done) return;
      end
      chk("u1_done_timeout", 0, 1);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      mode       = 0;
      rst        = 1'b1;
      bus2.start = 1'b0;
      bus1.start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_x", bus2.x, 0);
      chk("rst_y", bus2.y, 0);
      chk("rst_busy", bus2.busy, 0);
      chk("rst_done", bus2.done, 0);
      chk("rst_pass", bus2.pass, 0);
      chk("rst_err_count", bus2.err_count, 0);
      chk("rst_fail_vec", bus2.fail_vec, 0);
      rst = 1'b0;

      // nominal AND run with vector stepping checked cycle by cycle
      @(negedge clk);
      mode = 0;
      bus2.start = 1'b1;
      q2.push_back(model(0, 2, cyc + 1));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus2.start = 1'b0;
         chk("nom_xy", {bus2.x, bus2.y}, k / 2);
         chk("nom_busy", bus2.busy, 1);
      end
      @(negedge clk);
      chk("nom_done", bus2.done, 1);
      chk("nom_xy_fin", {bus2.x, bus2.y}, 0);
      @(negedge clk);
      chk("nom_done_one_cycle", bus2.done, 0);

      // wrong gate, results must hold afterwards
      start2(1);
      wait_done2();
      repeat (5) @(negedge clk);
      chk("hold_fail_vec", bus2.fail_vec, 4'b0110);
      chk("hold_err_count", bus2.err_count, 2);
      chk("hold_pass", bus2.pass, 0);

      // stuck-at-0 with SETTLE=1
      @(negedge clk);
      bus1.start = 1'b1;
      q1.push_back(model(2, 1, cyc + 1));
      @(negedge clk);
      bus1.start = 1'b0;
      wait_done1();

      // start pulse at E0+3 must be ignored
      start2(0);
      repeat (2) @(negedge clk);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      wait_done2();

      // asynchronous reset between E0+3 and E0+4
      start2(0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mrst_x", bus2.x, 0);
      chk("mrst_y", bus2.y, 0);
      chk("mrst_busy", bus2.busy, 0);
      chk("mrst_done", bus2.done, 0);
      chk("mrst_pass", bus2.pass, 0);
      chk("mrst_err_count", bus2.err_count, 0);
      chk("mrst_fail_vec", bus2.fail_vec, 0);
      q2.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("post_rst_busy", bus2.busy, 0);
         chk("post_rst_done", bus2.done, 0);
      end
      start2(0);
      wait_done2();

      // back-to-back: start held high through FIN
      @(negedge clk);
      mode = 1;
      bus2.start = 1'b1;
      q2.push_back(model(1, 2, cyc + 1));
      wait_done2();
      q2.push_back(model(1, 2, cyc + 1));
      @(negedge clk);
      bus2.start = 1'b0;
      chk("b2b_busy", bus2.busy, 1);
      chk("b2b_clr_fail_vec", bus2.fail_vec, 0);
      chk("b2b_clr_err_count", bus2.err_count, 0);
      chk("b2b_clr_pass", bus2.pass, 0);
      wait_done2();

      repeat (3) @(negedge clk);
      chk("q2_drained", q2.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
